// File: rtl/matmul_sequencer.sv
// Control sequencer for an N x N matrix multiply C = A x B.
// Streams A/B read addresses to a MAC, then writes each accumulated C element.
module matmul_sequencer #(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = (N > 1) ? $clog2(N * N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_clear,
    output logic          mac_enable,
    input  logic [31:0]   accum_in,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [31:0]   c_wdata
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW = 32;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] i_q, j_q, k_q;
    logic [CW-1:0] i_n, j_n, k_n;
    logic          busy_n, done_n, mac_clear_n, mac_enable_n, c_we_n;
    logic [AW-1:0] a_addr_n, b_addr_n, c_addr_n;
    logic [DW-1:0] wdata_q;

    // Row-major flattening of (row, col) into an AW-bit address.
    function automatic logic [AW-1:0] flat(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return AW'(AW'(r) * AW'(N) + AW'(c));
    endfunction

    // State, loop counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mac_clear  <= 1'b0;
            mac_enable <= 1'b0;
            c_we       <= 1'b0;
            a_addr     <= '0;
            b_addr     <= '0;
            c_addr     <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= state_n;
            i_q        <= i_n;
            j_q        <= j_n;
            k_q        <= k_n;
            busy       <= busy_n;
            done       <= done_n;
            mac_clear  <= mac_clear_n;
            mac_enable <= mac_enable_n;
            c_we       <= c_we_n;
            a_addr     <= a_addr_n;
            b_addr     <= b_addr_n;
            c_addr     <= c_addr_n;
            wdata_q    <= c_we ? accum_in : wdata_q;
        end
    end

    // Next state, counters and the next value of every registered output.
    always_comb begin
        state_n  = state;
        i_n      = i_q;
        j_n      = j_q;
        k_n      = k_q;
        a_addr_n = a_addr;
        b_addr_n = b_addr;
        c_addr_n = c_addr;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = CLEAR;
                    i_n     = '0;
                    j_n     = '0;
                    k_n     = '0;
                end
            end
            CLEAR: begin
                state_n = ISSUE;
                k_n     = '0;
            end
            ISSUE: begin
                if (k_q == LAST) begin
                    state_n = WAIT;
                end else begin
                    k_n = k_q + CW'(1);
                end
            end
            WAIT: begin
                state_n = WRITE;
            end
            WRITE: begin
                if (j_q == LAST) begin
                    j_n = '0;
                    if (i_q == LAST) begin
                        i_n     = '0;
                        state_n = DONE;
                    end else begin
                        i_n     = i_q + CW'(1);
                        state_n = CLEAR;
                    end
                end else begin
                    j_n     = j_q + CW'(1);
                    state_n = CLEAR;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort wins over every transition above once an operation is running.
        if (abort && (state != IDLE)) begin
            state_n = IDLE;
            i_n     = '0;
            j_n     = '0;
            k_n     = '0;
        end

        busy_n       = (state_n != IDLE);
        done_n       = (state_n == DONE);
        mac_clear_n  = (state_n == CLEAR);
        c_we_n       = (state_n == WRITE);
        mac_enable_n = (state == ISSUE) && !abort;

        if (state_n == ISSUE) begin
            a_addr_n = flat(i_n, k_n);
            b_addr_n = flat(k_n, j_n);
        end
        if (state_n == WRITE) begin
            c_addr_n = flat(i_n, j_n);
        end
    end

    // The MAC result only settles at the edge entering WRITE, so it is passed
    // straight through during the write and held afterwards.
    assign c_wdata = c_we ? accum_in : wdata_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: three instances (N=1,2,4) with behavioural
// memories and MAC, checked against a plain-arithmetic matrix product.
module tb_matmul_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_v[3];
    logic        abort_v[3];
    logic        bsy[3], dn[3], mcl[3], men[3], cwe[3];
    logic [31:0] acc[3], cwd[3], rda[3], rdb[3];
    logic [7:0]  aa[3], ba[3], ca[3];
    logic [0:0]  a1, b1, c1;
    logic [1:0]  a2, b2, c2;
    logic [3:0]  a4, b4, c4;
    logic [31:0] amem[3][16];
    logic [31:0] bmem[3][16];
    logic [31:0] cexp[16];

    int checks = 0;
    int errors = 0;

    int          r_done_at, r_ndone, r_nwe, r_we_after, r_done_after;
    int          r_nclr, r_nmen, r_addr_err;
    logic        r_busy_after, r_men_after, r_zero_after;
    int          wq_addr[$];
    logic [31:0] wq_data[$];

    matmul_sequencer #(.N(1)) u_n1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
        .busy(bsy[0]), .done(dn[0]), .a_addr(a1), .b_addr(b1),
        .mac_clear(mcl[0]), .mac_enable(men[0]), .accum_in(acc[0]),
        .c_we(cwe[0]), .c_addr(c1), .c_wdata(cwd[0])
    );
    matmul_sequencer #(.N(2)) u_n2 (
        .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
        .busy(bsy[1]), .done(dn[1]), .a_addr(a2), .b_addr(b2),
        .mac_clear(mcl[1]), .mac_enable(men[1]), .accum_in(acc[1]),
        .c_we(cwe[1]), .c_addr(c2), .c_wdata(cwd[1])
    );
    matmul_sequencer #(.N(4)) u_n4 (
        .clk(clk), .reset(reset), .start(start_v[2]), .abort(abort_v[2]),
        .busy(bsy[2]), .done(dn[2]), .a_addr(a4), .b_addr(b4),
        .mac_clear(mcl[2]), .mac_enable(men[2]), .accum_in(acc[2]),
        .c_we(cwe[2]), .c_addr(c4), .c_wdata(cwd[2])
    );

    assign aa[0] = 8'(a1);
    assign ba[0] = 8'(b1);
    assign ca[0] = 8'(c1);
    assign aa[1] = 8'(a2);
    assign ba[1] = 8'(b2);
    assign ca[1] = 8'(c2);
    assign aa[2] = 8'(a4);
    assign ba[2] = 8'(b4);
    assign ca[2] = 8'(c4);

    // Synchronous-read memories and a clear/accumulate MAC per instance.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            rda[d] <= amem[d][aa[d][3:0]];
            rdb[d] <= bmem[d][ba[d][3:0]];
            if (reset || mcl[d]) acc[d] <= 32'd0;
            else if (men[d])     acc[d] <= acc[d] + rda[d] * rdb[d];
        end
    end

    function automatic int nof(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 4;
    endfunction

    task automatic compute_expected(input int d);
        int n;
        n = nof(d);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                logic [31:0] s;
                s = 32'd0;
                for (int k = 0; k < n; k++) s = s + amem[d][r*n+k] * bmem[d][k*n+c];
                cexp[r*n+c] = s;
            end
    endtask

    task automatic fill_random(input int d);
        for (int e = 0; e < 16; e++) begin
            amem[d][e] = 32'($urandom_range(255, 0));
            bmem[d][e] = 32'($urandom_range(255, 0));
        end
    endtask

    // Pulse start, watch a fixed window, optionally inject start(1)/abort(2)/reset(3) in cycle act_cyc.
    task automatic run_op(input int d, input int act, input int act_cyc);
        int n;
        n = nof(d);
        r_done_at = 0; r_ndone = 0; r_nwe = 0; r_we_after = 0; r_done_after = 0;
        r_nclr = 0; r_nmen = 0; r_addr_err = 0;
        r_busy_after = 1'b1; r_men_after = 1'b1; r_zero_after = 1'b0;
        wq_addr.delete();
        wq_data.delete();
        @(negedge clk);
        start_v[d] = 1'b1;
        for (int cnt = 1; cnt <= n*n*(n+3) + 6; cnt++) begin
            @(negedge clk);
            start_v[d] = 1'b0;
            abort_v[d] = 1'b0;
            reset      = 1'b0;
            if (dn[d]) begin
                r_ndone++;
                if (r_done_at == 0) r_done_at = cnt;
                if (act != 0 && cnt > act_cyc) r_done_after++;
            end
            if (cwe[d]) begin
                r_nwe++;
                wq_addr.push_back(int'(ca[d]));
                wq_data.push_back(cwd[d]);
                if (act != 0 && cnt > act_cyc) r_we_after++;
            end
            if (mcl[d]) r_nclr++;
            if (men[d]) r_nmen++;
            if (int'(aa[d]) >= n*n || int'(ba[d]) >= n*n || int'(ca[d]) >= n*n) r_addr_err++;
            if (act != 0 && cnt == act_cyc + 1) begin
                r_busy_after = bsy[d];
                r_men_after  = men[d];
                r_zero_after = !bsy[d] && !dn[d] && !mcl[d] && !men[d] && !cwe[d] &&
                               aa[d] == 8'd0 && ba[d] == 8'd0 && ca[d] == 8'd0 && cwd[d] == 32'd0;
            end
            if (cnt == act_cyc) begin
                case (act)
                    1:       start_v[d] = 1'b1;
                    2:       abort_v[d] = 1'b1;
                    3:       reset = 1'b1;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0;
            abort_v[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({bsy[d], dn[d], mcl[d], men[d], cwe[d]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctl[%0d]: got %b, want 00000", d, {bsy[d], dn[d], mcl[d], men[d], cwe[d]});
            end
            checks++;
            if (aa[d] !== 8'd0 || ba[d] !== 8'd0 || ca[d] !== 8'd0 || cwd[d] !== 32'd0) begin
                errors++;
                $display("FAIL reset_data[%0d]: got a=%0d b=%0d c=%0d wd=%0d, want all 0", d, aa[d], ba[d], ca[d], cwd[d]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity_n2;
        for (int e = 0; e < 16; e++) begin amem[1][e] = 32'd0; bmem[1][e] = 32'd0; end
        amem[1][0] = 32'd1; amem[1][3] = 32'd1;
        bmem[1][0] = 32'd1; bmem[1][1] = 32'd2; bmem[1][2] = 32'd3; bmem[1][3] = 32'd4;
        compute_expected(1);
        run_op(1, 0, 0);
        checks++;
        if (r_done_at != 21 || r_ndone != 1) begin
            errors++;
            $display("FAIL ident_done: got cycle %0d count %0d, want cycle 21 count 1", r_done_at, r_ndone);
        end
        checks++;
        if (r_nwe != 4) begin errors++; $display("FAIL ident_nwe: got %0d, want 4", r_nwe); end
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (e >= wq_addr.size() || wq_addr[e] != e || wq_data[e] !== 32'(e + 1) || cexp[e] !== 32'(e + 1)) begin
                errors++;
                $display("FAIL ident_c[%0d]: got addr %0d data %0d, want addr %0d data %0d",
                         e, (e < wq_addr.size()) ? wq_addr[e] : -1, (e < wq_data.size()) ? wq_data[e] : 32'hx, e, e + 1);
            end
        end
    endtask

    task automatic test_n4;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                amem[2][r*4+c] = 32'(r + 1);
                bmem[2][r*4+c] = 32'(c + 1);
            end
        compute_expected(2);
        run_op(2, 0, 0);
        checks++;
        if (r_done_at != 113 || r_ndone != 1) begin
            errors++;
            $display("FAIL n4_done: got cycle %0d count %0d, want cycle 113 count 1", r_done_at, r_ndone);
        end
        checks++;
        if (wq_data.size() != 16 || wq_data[15] !== 32'd64) begin
            errors++;
            $display("FAIL n4_c33: got %0d writes last %0d, want 16 writes last 64", wq_data.size(),
                     (wq_data.size() > 0) ? wq_data[wq_data.size()-1] : 32'hx);
        end
        for (int e = 0; e < 16; e++) begin
            checks++;
            if (e >= wq_addr.size() || wq_addr[e] != e || wq_data[e] !== cexp[e]) begin
                errors++;
                $display("FAIL n4_c[%0d]: got %0d, want %0d", e, (e < wq_data.size()) ? wq_data[e] : 32'hx, cexp[e]);
            end
        end
    endtask

    task automatic test_n1;
        amem[0][0] = 32'd7;
        bmem[0][0] = 32'd6;
        run_op(0, 0, 0);
        checks++;
        if (r_nwe != 1 || wq_addr.size() != 1 || wq_addr[0] != 0 || wq_data[0] !== 32'd42) begin
            errors++;
            $display("FAIL n1_c: got %0d writes data %0d, want 1 write of 42 at 0", r_nwe,
                     (wq_data.size() > 0) ? wq_data[0] : 32'hx);
        end
        checks++;
        if (r_done_at != 5 || r_ndone != 1) begin
            errors++;
            $display("FAIL n1_done: got cycle %0d count %0d, want cycle 5 count 1", r_done_at, r_ndone);
        end
    endtask

    task automatic test_restart_ignored;
        fill_random(1);
        compute_expected(1);
        run_op(1, 1, 5);
        checks++;
        if (r_done_at != 21 || r_ndone != 1 || r_nwe != 4) begin
            errors++;
            $display("FAIL restart: got done %0d x%0d writes %0d, want done 21 x1 writes 4", r_done_at, r_ndone, r_nwe);
        end
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (e >= wq_data.size() || wq_data[e] !== cexp[e]) begin
                errors++;
                $display("FAIL restart_c[%0d]: got %0d, want %0d", e, (e < wq_data.size()) ? wq_data[e] : 32'hx, cexp[e]);
            end
        end
    endtask

    task automatic test_abort;
        fill_random(1);
        compute_expected(1);
        run_op(1, 2, 8);
        checks++;
        if (r_busy_after !== 1'b0 || r_men_after !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got busy %b mac_enable %b, want 0 0", r_busy_after, r_men_after);
        end
        checks++;
        if (r_we_after != 0 || r_ndone != 0 || r_nwe != 1) begin
            errors++;
            $display("FAIL abort_quiet: got late writes %0d done %0d writes %0d, want 0 0 1", r_we_after, r_ndone, r_nwe);
        end
        run_op(1, 0, 0);
        checks++;
        if (r_done_at != 21 || r_nwe != 4 || wq_data.size() != 4 || wq_data[3] !== cexp[3]) begin
            errors++;
            $display("FAIL abort_rerun: got done %0d writes %0d, want done 21 writes 4 with C(1,1)=%0d", r_done_at, r_nwe, cexp[3]);
        end
    endtask

    task automatic test_reset_mid;
        fill_random(1);
        compute_expected(1);
        run_op(1, 3, 10);
        checks++;
        if (r_zero_after !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_zero: got outputs-zero %b, want 1", r_zero_after);
        end
        checks++;
        if (r_we_after != 0 || r_done_after != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got late writes %0d done %0d, want 0 0", r_we_after, r_done_after);
        end
        run_op(1, 0, 0);
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (e >= wq_data.size() || wq_addr[e] != e || wq_data[e] !== cexp[e]) begin
                errors++;
                $display("FAIL reset_rerun_c[%0d]: got %0d, want %0d", e, (e < wq_data.size()) ? wq_data[e] : 32'hx, cexp[e]);
            end
        end
    endtask

    task automatic test_start_abort_idle;
        int seen_busy;
        seen_busy = 0;
        @(negedge clk);
        start_v[1] = 1'b1;
        abort_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        abort_v[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (bsy[1] || dn[1] || mcl[1]) seen_busy++;
            @(negedge clk);
        end
        checks++;
        if (seen_busy != 0) begin
            errors++;
            $display("FAIL start_abort_idle: got %0d active cycles, want 0", seen_busy);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 3; it++)
            for (int d = 0; d < 3; d++) begin
                int n;
                n = nof(d);
                fill_random(d);
                compute_expected(d);
                run_op(d, 0, 0);
                checks++;
                if (r_done_at != n*n*(n+3) + 1 || r_ndone != 1) begin
                    errors++;
                    $display("FAIL rand_done N=%0d: got cycle %0d x%0d, want cycle %0d x1", n, r_done_at, r_ndone, n*n*(n+3) + 1);
                end
                checks++;
                if (r_nclr != n*n || r_nmen != n*n*n || r_addr_err != 0) begin
                    errors++;
                    $display("FAIL rand_mac N=%0d: got clears %0d enables %0d bad addrs %0d, want %0d %0d 0",
                             n, r_nclr, r_nmen, r_addr_err, n*n, n*n*n);
                end
                for (int e = 0; e < n*n; e++) begin
                    checks++;
                    if (e >= wq_data.size() || wq_addr[e] != e || wq_data[e] !== cexp[e]) begin
                        errors++;
                        $display("FAIL rand_c N=%0d [%0d]: got %0d, want %0d", n, e,
                                 (e < wq_data.size()) ? wq_data[e] : 32'hx, cexp[e]);
                    end
                end
            end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0;
            abort_v[d] = 1'b0;
            for (int e = 0; e < 16; e++) begin
                amem[d][e] = 32'd0;
                bmem[d][e] = 32'd0;
            end
        end
        test_reset();
        test_identity_n2();
        test_n4();
        test_n1();
        test_restart_ignored();
        test_abort();
        test_reset_mid();
        test_start_abort_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
